time_entry_controller: RTL
==========================

Name: time_entry_controller

Overview:
- Keypad-side front end for the minutes/seconds countdown timer. It collects typed digits into a BCD M:SS value and validates it on Start.
- It drives the timer's initial-value, Load and Enable inputs, and watches timer_done to sequence run, pause and done-alarm.
- It sits between the keypad decoder and the countdown timer in the microwave top level.

Parameters:
- ALARM_CYCLES, 3, number of CLK cycles done_alarm stays high after countdown completes (1..15).
- MAX_DIGITS, 3, digits accepted per entry; further digit keys are ignored.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- Clear  input  1  asynchronous active-high reset.
- key_valid  input  1  one-cycle pulse: key_code is valid this cycle.
- key_code  input  4  0-9 digit; 0xA Start; 0xB Stop/Cancel; 0xC Clear-entry; 0xD-0xF ignored.
- door_closed  input  1  level, 1 = door shut.
- timer_done  input  1  registered "count is zero" flag from the timer.
- entry_seconds_units  output  4  BCD, drives timer initial_seconds_units.
- entry_seconds_tens  output  4  BCD, drives timer initial_seconds_tens.
- entry_minutes_units  output  4  BCD, drives timer initial_minutes_units.
- Load  output  1  one-cycle pulse that loads the entry into the timer.
- Enable  output  1  level, timer counts while high.
- entry_error  output  1  one-cycle pulse when a Start is rejected.
- done_alarm  output  1  high for ALARM_CYCLES cycles at end of cook.
- state  output  3  encoded FSM state for display/debug.

Behaviour:
- Reset (async, Clear=1) drives all outputs to 0, digit count to 0 and the FSM to IDLE. Clear asserted mid-run stops Enable immediately, with no Load.
- FSM states and encoding: IDLE=0, ENTRY=1, LOAD=2, RUN=3, PAUSED=4, DONE=5. Codes 6-7 are unused and recover to IDLE.
- Digit entry:
  - Digit key in IDLE/ENTRY with count<MAX_DIGITS shifts left: min_units<=sec_tens, sec_tens<=sec_units, sec_units<=digit, count++.
  - A digit in IDLE moves the FSM to ENTRY.
  - A digit with count=MAX_DIGITS is ignored, with no error.
- Clear-entry (0xC) in IDLE/ENTRY zeroes all three digits and the count, and goes to IDLE.
- Start (0xA) in ENTRY is accepted only if all of the following hold:
  - door_closed=1;
  - entry_seconds_tens<=5;
  - the entry is not all-zero.
  - If accepted, go to LOAD. Otherwise pulse entry_error for 1 cycle and stay in ENTRY with digits unchanged.
  - Start in IDLE pulses entry_error.
- LOAD:
  - Load=1 for exactly one cycle, with entry outputs stable.
  - The next state is always RUN. Keys in LOAD are ignored.
- RUN:
  - Enable=1.
  - timer_done is blanked for the first RUN cycle entered from LOAD, because the timer's flag still reflects pre-load contents. It is sampled from the second cycle on.
  - The blanking cycle applies only on entry from LOAD, not from PAUSED.
  - Transitions out of RUN:
    - timer_done=1 → DONE.
    - Stop key or door_closed=0 → PAUSED.
    - Simultaneous timer_done and Stop/door-open → DONE wins.
- PAUSED:
  - Enable=0 and the timer holds its value.
  - Start with door_closed=1 → RUN, with no Load and no blanking.
  - Start with door open pulses entry_error.
  - Stop → IDLE, clearing the entry digits and count.
- DONE:
  - Enable=0 and done_alarm=1.
  - An internal counter starts at ALARM_CYCLES and decrements each cycle; at 1 the FSM goes to IDLE.
  - Any key in DONE → IDLE immediately, and the key is otherwise consumed.
  - The entry is cleared on entering IDLE from DONE.
- Entry digits are frozen in LOAD/RUN/PAUSED/DONE; digit keys there are ignored.
- key_valid with key_code 0xD-0xF is a no-op in every state.
- Outputs are registered: Load, Enable and done_alarm change only on CLK edges, never combinationally from inputs.

Test Plan:
- Reset, then keys 1,3,0, Start with door closed → entry = 1:30 (min=1, tens=3, units=0); Load high one cycle; Enable=1 from the next cycle; state 2→3.
- Keys 9,0, Start → entry_error pulses (tens=9>5); state stays ENTRY; digits unchanged. Keys 0xC then 5, Start → Load pulses, 0:05 loaded.
- Keys 1,2,3,4 → entry = 1:23; the fourth digit is ignored and the count stays 3.
- RUN with timer_done=1 present in the first RUN cycle → ignored. timer_done held into the second cycle → DONE; done_alarm high 3 cycles, then IDLE with outputs 0.
- RUN: door_closed→0 → PAUSED, Enable=0. Door closed, Start → RUN with no Load pulse. Stop, then Stop again → IDLE with entry zeroed.
- Same cycle timer_done=1 and Stop key during RUN → DONE. Clear pulsed mid-DONE → all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/time_entry_controller.sv
// Keypad front end for the M:SS countdown timer: collects BCD digits, validates Start,
// and sequences timer load, run, pause and the end-of-cook alarm.
module time_entry_controller #(
    parameter int ALARM_CYCLES = 3,
    parameter int MAX_DIGITS   = 3
) (
    input  logic       CLK,
    input  logic       Clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       door_closed,
    input  logic       timer_done,
    output logic [3:0] entry_seconds_units,
    output logic [3:0] entry_seconds_tens,
    output logic [3:0] entry_minutes_units,
    output logic       Load,
    output logic       Enable,
    output logic       entry_error,
    output logic       done_alarm,
    output logic [2:0] state
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_PAUSED = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [3:0]         r_sec_units;
    logic [3:0]         r_sec_tens;
    logic [3:0]         r_min_units;
    logic [CNT_W-1:0]   r_count;
    logic               r_blank;
    logic [3:0]         r_alarm_cnt;
    logic               r_load;
    logic               r_enable;
    logic               r_error;
    logic               r_done_alarm;

    logic [3:0]         w_sec_units_nx;
    logic [3:0]         w_sec_tens_nx;
    logic [3:0]         w_min_units_nx;
    logic [CNT_W-1:0]   w_count_nx;
    logic               w_blank_nx;
    logic [3:0]         w_alarm_cnt_nx;
    logic               w_error_nx;

    logic               w_key_digit;
    logic               w_key_start;
    logic               w_key_stop;
    logic               w_key_clear;
    logic               w_key_any;
    logic               w_entry_ok;

    // Codes 0xD-0xF never count as a key, so they are a no-op everywhere.
    assign w_key_digit = key_valid && (key_code <= 4'd9);
    assign w_key_start = key_valid && (key_code == 4'hA);
    assign w_key_stop  = key_valid && (key_code == 4'hB);
    assign w_key_clear = key_valid && (key_code == 4'hC);
    assign w_key_any   = w_key_digit || w_key_start || w_key_stop || w_key_clear;

    assign w_entry_ok = door_closed
                     && (r_sec_tens <= 4'd5)
                     && (|{r_min_units, r_sec_tens, r_sec_units});

    // State register
    always_ff @(posedge CLK or posedge Clear) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, entry datapath and pulse decisions
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_next_state   = r_state;
        w_sec_units_nx = r_sec_units;
        w_sec_tens_nx  = r_sec_tens;
        w_min_units_nx = r_min_units;
        w_count_nx     = r_count;
        w_blank_nx     = 1'b0;
        w_alarm_cnt_nx = r_alarm_cnt;
        w_error_nx     = 1'b0;

        case (r_state)
            ST_IDLE, ST_ENTRY: begin
                if (w_key_digit) begin
                    if (r_count < CNT_W'(MAX_DIGITS)) begin
                        w_min_units_nx = r_sec_tens;
                        w_sec_tens_nx  = r_sec_units;
                        w_sec_units_nx = key_code;
                        w_count_nx     = r_count + CNT_W'(1);
                    end
                    w_next_state = ST_ENTRY;
                end else if (w_key_clear) begin
                    w_sec_units_nx = 4'd0;
                    w_sec_tens_nx  = 4'd0;
                    w_min_units_nx = 4'd0;
                    w_count_nx     = '0;
                    w_next_state   = ST_IDLE;
                end else if (w_key_start) begin
                    if ((r_state == ST_ENTRY) && w_entry_ok) begin
                        w_next_state = ST_LOAD;
                    end else begin
                        w_error_nx = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                // The timer's done flag is stale for one cycle after a load.
                w_next_state = ST_RUN;
                w_blank_nx   = 1'b1;
            end

            ST_RUN: begin
                if (timer_done && !r_blank) begin
                    w_next_state   = ST_DONE;
                    w_alarm_cnt_nx = 4'(ALARM_CYCLES);
                end else if (w_key_stop || !door_closed) begin
                    w_next_state = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                if (w_key_start) begin
                    if (door_closed) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_error_nx = 1'b1;
                    end
                end else if (w_key_stop) begin
                    w_sec_units_nx = 4'd0;
                    w_sec_tens_nx  = 4'd0;
                    w_min_units_nx = 4'd0;
                    w_count_nx     = '0;
                    w_next_state   = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (w_key_any || (r_alarm_cnt <= 4'd1)) begin
                    w_sec_units_nx = 4'd0;
                    w_sec_tens_nx  = 4'd0;
                    w_min_units_nx = 4'd0;
                    w_count_nx     = '0;
                    w_next_state   = ST_IDLE;
                end else begin
                    w_alarm_cnt_nx = r_alarm_cnt - 4'd1;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Entry registers and registered outputs, decoded from the next state
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            r_sec_units  <= 4'd0;
            r_sec_tens   <= 4'd0;
            r_min_units  <= 4'd0;
            r_count      <= '0;
            r_blank      <= 1'b0;
            r_alarm_cnt  <= 4'd0;
            r_load       <= 1'b0;
            r_enable     <= 1'b0;
            r_error      <= 1'b0;
            r_done_alarm <= 1'b0;
        end else begin
            r_sec_units  <= w_sec_units_nx;
            r_sec_tens   <= w_sec_tens_nx;
            r_min_units  <= w_min_units_nx;
            r_count      <= w_count_nx;
            r_blank      <= w_blank_nx;
            r_alarm_cnt  <= w_alarm_cnt_nx;
            r_load       <= (w_next_state == ST_LOAD);
            r_enable     <= (w_next_state == ST_RUN);
            r_error      <= w_error_nx;
            r_done_alarm <= (w_next_state == ST_DONE);
        end
    end

    assign entry_seconds_units = r_sec_units;
    assign entry_seconds_tens  = r_sec_tens;
    assign entry_minutes_units = r_min_units;
    assign Load                = r_load;
    assign Enable              = r_enable;
    assign entry_error         = r_error;
    assign done_alarm          = r_done_alarm;
    assign state               = r_state;

endmodule
